// File: rtl/bsg_wormhole_loopback_traffic_node.sv
// Loopback traffic generator/checker for wormhole links: per channel it injects
// self-describing packets, checks what comes back, and keeps sent/received/error stats.
module bsg_wormhole_loopback_traffic_node #(
  parameter int flit_width_p      = 32,
  parameter int num_channels_p    = 2,
  parameter int cord_width_p      = 4,
  parameter int len_width_p       = 4,
  parameter int max_len_p         = 3,
  parameter int max_outstanding_p = 16
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_channels_p-1:0]              en_i,
  input  logic                                   mode_i,
  input  logic [cord_width_p-1:0]                dest_cord_i,
  output logic [num_channels_p-1:0]              v_o,
  output logic [num_channels_p*flit_width_p-1:0] data_o,
  input  logic [num_channels_p-1:0]              ready_i,
  input  logic [num_channels_p-1:0]              v_i,
  input  logic [num_channels_p*flit_width_p-1:0] data_i,
  output logic [num_channels_p-1:0]              yumi_o,
  output logic [num_channels_p-1:0]              error_o,
  output logic [num_channels_p*32-1:0]           sent_o,
  output logic [num_channels_p*32-1:0]           received_o,
  output logic                                   done_o
);

  localparam int out_width_lp = $clog2(max_outstanding_p + 1);

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HDR  = 2'd1,
    TX_BODY = 2'd2
  } tx_state_e;

  typedef enum logic {
    RX_HDR  = 1'b0,
    RX_BODY = 1'b1
  } rx_state_e;

  function automatic logic [len_width_p-1:0] pkt_len(input logic mode, input logic [7:0] seq);
    logic [7:0] m;
    if (mode) begin
      m = seq % 8'(max_len_p + 1);
    end else begin
      m = 8'(max_len_p);
    end
    return len_width_p'(m);
  endfunction

  // x^16+x^14+x^13+x^11+1, Fibonacci form
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [flit_width_p-1:0] hdr_flit(input logic [cord_width_p-1:0] cord,
                                                       input logic [len_width_p-1:0]  len,
                                                       input logic [7:0]              seq);
    logic [flit_width_p-1:0] f;
    f = '0;
    f[cord_width_p-1:0] = cord;
    f[cord_width_p +: len_width_p] = len;
    f[cord_width_p + len_width_p +: 8] = seq;
    return f;
  endfunction

  function automatic logic [flit_width_p-1:0] body_flit(input logic                   mode,
                                                        input logic [7:0]             seq,
                                                        input logic [len_width_p-1:0] k,
                                                        input logic [15:0]            lfsr);
    logic [flit_width_p-1:0] f;
    f = '0;
    if (mode) begin
      for (int i = 0; i < flit_width_p; i++) begin
        f[i] = lfsr[4'(i % 16)];
      end
    end else begin
      f[len_width_p-1:0] = k;
      f[len_width_p +: 8] = seq;
    end
    return f;
  endfunction

  logic [num_channels_p-1:0] chan_idle;
  logic                      done_q;

  for (genvar ch = 0; ch < num_channels_p; ch++) begin : chan
    tx_state_e               tx_state_q, tx_state_d;
    logic                    tx_v_q, tx_v_d;
    logic [7:0]              tx_seq_q, tx_seq_d;
    logic [len_width_p-1:0]  tx_len_q, tx_len_d;
    logic [len_width_p-1:0]  tx_k_q, tx_k_d;
    logic [15:0]             tx_lfsr_q, tx_lfsr_d;
    logic [flit_width_p-1:0] tx_data_q, tx_data_d;
    logic                    tx_fire, tx_done, tx_launch, can_start;

    rx_state_e               rx_state_q, rx_state_d;
    logic [7:0]              rx_seq_q, rx_seq_d;
    logic [len_width_p-1:0]  rx_len_q, rx_len_d;
    logic [len_width_p-1:0]  rx_k_q, rx_k_d;
    logic [15:0]             rx_lfsr_q, rx_lfsr_d;
    logic [len_width_p-1:0]  rx_exp_len;
    logic [flit_width_p-1:0] rx_flit;
    logic                    rx_mismatch, rx_done;

    logic [out_width_lp-1:0] out_q, out_d;
    logic                    error_q, error_d;
    logic [31:0]             sent_q, sent_d;
    logic [31:0]             recv_q, recv_d;

    assign rx_flit   = data_i[ch*flit_width_p +: flit_width_p];
    assign tx_fire   = tx_v_q & ready_i[ch];
    assign tx_done   = tx_fire & (((tx_state_q == TX_HDR) && (tx_len_q == '0))
                               || ((tx_state_q == TX_BODY) && (tx_k_q == tx_len_q)));
    assign can_start = en_i[ch] && (out_d < out_width_lp'(max_outstanding_p));

    // TX sequencing; a finishing packet chains straight into the next header to keep full rate
    always_comb begin
      tx_state_d = tx_state_q;
      tx_v_d     = tx_v_q;
      tx_seq_d   = tx_seq_q;
      tx_len_d   = tx_len_q;
      tx_k_d     = tx_k_q;
      tx_lfsr_d  = tx_lfsr_q;
      tx_data_d  = tx_data_q;
      tx_launch  = 1'b0;
      case (tx_state_q)
        TX_IDLE: tx_launch = can_start;
        TX_HDR: begin
          if (tx_fire && (tx_len_q == '0)) begin
            tx_state_d = TX_IDLE;
            tx_v_d     = 1'b0;
            tx_seq_d   = tx_seq_q + 8'd1;
            tx_launch  = can_start;
          end else if (tx_fire) begin
            tx_state_d = TX_BODY;
            tx_k_d     = len_width_p'(1);
            tx_data_d  = body_flit(mode_i, tx_seq_q, len_width_p'(1), tx_lfsr_q);
          end else begin
            tx_state_d = TX_HDR;
          end
        end
        TX_BODY: begin
          if (tx_fire) begin
            tx_lfsr_d = lfsr_next(tx_lfsr_q);
            if (tx_k_q == tx_len_q) begin
              tx_state_d = TX_IDLE;
              tx_v_d     = 1'b0;
              tx_seq_d   = tx_seq_q + 8'd1;
              tx_launch  = can_start;
            end else begin
              tx_k_d    = tx_k_q + len_width_p'(1);
              tx_data_d = body_flit(mode_i, tx_seq_q, tx_k_d, tx_lfsr_d);
            end
          end else begin
            tx_state_d = TX_BODY;
          end
        end
        default: begin
          tx_state_d = TX_IDLE;
          tx_v_d     = 1'b0;
        end
      endcase
      if (tx_launch) begin
        tx_state_d = TX_HDR;
        tx_v_d     = 1'b1;
        tx_len_d   = pkt_len(mode_i, tx_seq_d);
        tx_k_d     = '0;
        tx_data_d  = hdr_flit(dest_cord_i, tx_len_d, tx_seq_d);
      end
    end

    // RX checker follows the expected length, not the received one, so it stays in lockstep
    always_comb begin
      rx_state_d  = rx_state_q;
      rx_seq_d    = rx_seq_q;
      rx_len_d    = rx_len_q;
      rx_k_d      = rx_k_q;
      rx_lfsr_d   = rx_lfsr_q;
      rx_mismatch = 1'b0;
      rx_done     = 1'b0;
      rx_exp_len  = pkt_len(mode_i, rx_seq_q);
      case (rx_state_q)
        RX_HDR: begin
          if (v_i[ch]) begin
            rx_mismatch = (rx_flit != hdr_flit(dest_cord_i, rx_exp_len, rx_seq_q));
            if (rx_exp_len == '0) begin
              rx_done  = 1'b1;
              rx_seq_d = rx_seq_q + 8'd1;
            end else begin
              rx_state_d = RX_BODY;
              rx_len_d   = rx_exp_len;
              rx_k_d     = len_width_p'(1);
            end
          end else begin
            rx_state_d = RX_HDR;
          end
        end
        RX_BODY: begin
          if (v_i[ch]) begin
            rx_mismatch = (rx_flit != body_flit(mode_i, rx_seq_q, rx_k_q, rx_lfsr_q));
            rx_lfsr_d   = lfsr_next(rx_lfsr_q);
            if (rx_k_q == rx_len_q) begin
              rx_done    = 1'b1;
              rx_seq_d   = rx_seq_q + 8'd1;
              rx_state_d = RX_HDR;
            end else begin
              rx_k_d = rx_k_q + len_width_p'(1);
            end
          end else begin
            rx_state_d = RX_BODY;
          end
        end
        default: rx_state_d = RX_HDR;
      endcase
    end

    // In-flight accounting, sticky error and statistics
    always_comb begin
      case ({tx_done, rx_done})
        2'b10:   out_d = out_q + out_width_lp'(1);
        2'b01:   out_d = (out_q == '0) ? '0 : out_q - out_width_lp'(1);
        default: out_d = out_q;
      endcase
      error_d = error_q | rx_mismatch | (rx_done & ~tx_done & (out_q == '0));
      sent_d  = sent_q + 32'(tx_done);
      recv_d  = recv_q + 32'(rx_done);
    end

    // Channel state registers
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        tx_state_q <= TX_IDLE;
        tx_v_q     <= 1'b0;
        tx_seq_q   <= 8'd0;
        tx_len_q   <= '0;
        tx_k_q     <= '0;
        tx_lfsr_q  <= 16'h0001 + 16'(ch);
        tx_data_q  <= '0;
        rx_state_q <= RX_HDR;
        rx_seq_q   <= 8'd0;
        rx_len_q   <= '0;
        rx_k_q     <= '0;
        rx_lfsr_q  <= 16'h0001 + 16'(ch);
        out_q      <= '0;
        error_q    <= 1'b0;
        sent_q     <= 32'd0;
        recv_q     <= 32'd0;
      end else begin
        tx_state_q <= tx_state_d;
        tx_v_q     <= tx_v_d;
        tx_seq_q   <= tx_seq_d;
        tx_len_q   <= tx_len_d;
        tx_k_q     <= tx_k_d;
        tx_lfsr_q  <= tx_lfsr_d;
        tx_data_q  <= tx_data_d;
        rx_state_q <= rx_state_d;
        rx_seq_q   <= rx_seq_d;
        rx_len_q   <= rx_len_d;
        rx_k_q     <= rx_k_d;
        rx_lfsr_q  <= rx_lfsr_d;
        out_q      <= out_d;
        error_q    <= error_d;
        sent_q     <= sent_d;
        recv_q     <= recv_d;
      end
    end

    assign chan_idle[ch] = ~en_i[ch] & (out_d == '0) & (tx_state_d == TX_IDLE);

    assign v_o[ch]                                   = tx_v_q;
    assign data_o[ch*flit_width_p +: flit_width_p]   = tx_data_q;
    assign yumi_o[ch]                                = v_i[ch];
    assign error_o[ch]                               = error_q;
    assign sent_o[ch*32 +: 32]                       = sent_q;
    assign received_o[ch*32 +: 32]                   = recv_q;
  end

  // Global drain flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      done_q <= (en_i == '0);
    end else begin
      done_q <= &chan_idle;
    end
  end

  assign done_o = done_q;

endmodule

// File: tb/tb_bsg_wormhole_loopback_traffic_node.sv
// Randomized loopback bench: a queue-based packet model predicts every transmitted flit.
module tb_bsg_wormhole_loopback_traffic_node;
  localparam int NCH    = 2;
  localparam int MAXLEN = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [1:0]  en_i;
  logic        mode_i;
  logic [3:0]  dest_cord_i;
  logic [1:0]  v_o, v_i, yumi_o, error_o;
  logic [1:0]  ready_i = 2'b11;
  logic [63:0] data_o, data_i, sent_o, received_o;
  logic [63:0] flip_mask;
  logic        done_o;

  logic        loop_en, rand_ready, flip_armed, err_pending, rec_len;
  int          n_cmp, n_err;

  logic [31:0] exp_q [NCH][$];
  int          m_seq  [NCH];
  int          m_sent [NCH];
  int          m_pos  [NCH];
  logic [15:0] m_lfsr [NCH];
  logic        stall_prev [NCH];
  logic [31:0] stall_data [NCH];
  int          hdr_lens [$];

  assign v_i    = loop_en ? (v_o & ready_i) : 2'b00;
  assign data_i = data_o ^ flip_mask;

  bsg_wormhole_loopback_traffic_node dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .mode_i(mode_i), .dest_cord_i(dest_cord_i),
    .v_o(v_o), .data_o(data_o), .ready_i(ready_i), .v_i(v_i), .data_i(data_i),
    .yumi_o(yumi_o), .error_o(error_o), .sent_o(sent_o), .received_o(received_o), .done_o(done_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expand one packet of the model's stream into flits
  task automatic build_pkt(input int ch);
    int         len;
    logic [7:0] s8;
    logic [15:0] l;
    len = mode_i ? (m_seq[ch] % (MAXLEN + 1)) : MAXLEN;
    s8  = 8'(m_seq[ch] % 256);
    exp_q[ch].push_back({16'd0, s8, 4'(len), dest_cord_i});
    for (int k = 1; k <= len; k++) begin
      if (mode_i) begin
        l = m_lfsr[ch];
        exp_q[ch].push_back({l, l});
        m_lfsr[ch] = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end else begin
        exp_q[ch].push_back({20'd0, s8, 4'(k)});
      end
    end
    m_pos[ch] = -1;
  endtask

  always @(negedge clk) ready_i = rand_ready ? 2'($urandom) : 2'b11;

  // Scoreboard: predicts each flit about to be accepted at the next rising edge
  always @(negedge clk) begin : monitor
    logic [31:0] flit, expv;
    #1;
    flip_mask = 64'd0;
    if (err_pending) begin
      check("err_rise", {63'd0, error_o[0]}, 64'd1);
      err_pending = 1'b0;
    end
    if (reset_i) begin
      for (int ch = 0; ch < NCH; ch++) begin
        exp_q[ch].delete();
        m_seq[ch]      = 0;
        m_sent[ch]     = 0;
        m_pos[ch]      = -1;
        m_lfsr[ch]     = 16'(1 + ch);
        stall_prev[ch] = 1'b0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        flit = data_o[ch*32 +: 32];
        if (stall_prev[ch]) begin
          check("stall_v", {63'd0, v_o[ch]}, 64'd1);
          check("stall_data", {32'd0, flit}, {32'd0, stall_data[ch]});
        end
        if (v_o[ch] && ready_i[ch]) begin
          stall_prev[ch] = 1'b0;
          if (exp_q[ch].size() == 0) build_pkt(ch);
          m_pos[ch]++;
          expv = exp_q[ch].pop_front();
          check("tx_flit", {32'd0, flit}, {32'd0, expv});
          if (rec_len && ch == 0 && m_pos[0] == 0) hdr_lens.push_back(int'(flit[7:4]));
          if (flip_armed && ch == 0 && m_seq[0] == 7 && m_pos[0] == 3) begin
            flip_mask[5] = 1'b1;
            flip_armed   = 1'b0;
            check("err_before", {63'd0, error_o[0]}, 64'd0);
            err_pending  = 1'b1;
          end
          if (exp_q[ch].size() == 0) begin
            m_sent[ch]++;
            m_seq[ch]++;
          end
        end else begin
          stall_prev[ch] = v_o[ch];
          stall_data[ch] = flit;
        end
      end
    end
  end

  task automatic do_reset();
    reset_i = 1'b1;
    en_i    = 2'b00;
    cyc(3);
    reset_i = 1'b0;
    cyc(1);
  endtask

  task automatic drain();
    int i;
    en_i = 2'b00;
    for (i = 0; i < 400 && !done_o; i++) cyc(1);
    cyc(2);
    check("drain_done", {63'd0, done_o}, 64'd1);
    check("drain_v", {62'd0, v_o}, 64'd0);
  endtask

  task automatic check_stats(input string tag);
    for (int ch = 0; ch < NCH; ch++) begin
      check({tag, "_sent"}, {32'd0, sent_o[ch*32 +: 32]}, 64'(m_sent[ch]));
      check({tag, "_recv"}, {32'd0, received_o[ch*32 +: 32]}, 64'(m_sent[ch]));
    end
    check({tag, "_err"}, {62'd0, error_o}, 64'd0);
  endtask

  initial begin : stim
    int cnt [4];
    int i;
    logic found;
    n_cmp = 0; n_err = 0;
    reset_i = 1'b1; en_i = 2'b00; mode_i = 1'b0; dest_cord_i = 4'h5;
    loop_en = 1'b1; rand_ready = 1'b0; flip_armed = 1'b0; err_pending = 1'b0;
    rec_len = 1'b0; flip_mask = 64'd0;
    do_reset();

    // reset state
    check("rst_v", {62'd0, v_o}, 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_err", {62'd0, error_o}, 64'd0);
    check("rst_sent", sent_o, 64'd0);
    check("rst_recv", received_o, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd1);

    // 1: mode0 direct loop, 1000 cycles; header the cycle after enable, 1 pkt per 4 cycles
    en_i = 2'b11;
    cyc(1);
    check("t1_first_v", {62'd0, v_o}, 64'd3);
    check("t1_first_hdr", {32'd0, data_o[31:0]}, 64'h35);
    cyc(999);
    check("t1_rate0", {32'd0, sent_o[31:0]}, 64'd249);
    check("t1_rate1", {32'd0, sent_o[63:32]}, 64'd249);
    drain();
    check_stats("t1");

    // 2: mode1 length sweep over 40 packets
    do_reset();
    mode_i = 1'b1; rec_len = 1'b1; hdr_lens.delete();
    en_i = 2'b01;
    for (i = 0; i < 600 && m_sent[0] < 40; i++) cyc(1);
    check("t2_reach40", {63'd0, m_sent[0] >= 40}, 64'd1);
    drain();
    rec_len = 1'b0;
    for (int j = 0; j < 4; j++) cnt[j] = 0;
    for (int j = 0; j < 40 && j < hdr_lens.size(); j++) cnt[hdr_lens[j] % 4]++;
    for (int j = 0; j < 4; j++) check("t2_len_hist", 64'(cnt[j]), 64'd10);
    for (int j = 0; j < 8 && j < hdr_lens.size(); j++) check("t2_len_order", 64'(hdr_lens[j]), 64'(j % 4));
    check_stats("t2");

    // 3: broken loop saturates at the outstanding cap
    do_reset();
    mode_i = 1'b0; loop_en = 1'b0;
    en_i = 2'b01;
    cyc(200);
    check("t3_sent", {32'd0, sent_o[31:0]}, 64'd16);
    check("t3_v", {63'd0, v_o[0]}, 64'd0);
    check("t3_done_en", {63'd0, done_o}, 64'd0);
    en_i = 2'b00;
    cyc(10);
    check("t3_done_off", {63'd0, done_o}, 64'd0);
    check("t3_recv", received_o, 64'd0);
    loop_en = 1'b1;
    do_reset();

    // 4: corrupt bit 5 of the 3rd body flit of packet seq 7 on channel 0
    en_i = 2'b11; flip_armed = 1'b1;
    cyc(100);
    check("t4_injected", {63'd0, flip_armed}, 64'd0);
    check("t4_err", {62'd0, error_o}, 64'd1);
    drain();
    check("t4_sticky", {62'd0, error_o}, 64'd1);
    do_reset();
    check("t4_err_clr", {62'd0, error_o}, 64'd0);

    // 5: random ready stalls, mode1
    mode_i = 1'b1; dest_cord_i = 4'hA; rand_ready = 1'b1;
    en_i = 2'b11;
    cyc(800);
    drain();
    rand_ready = 1'b0;
    cyc(2);
    check("t5_progress", {63'd0, m_sent[0] > 50}, 64'd1);
    check_stats("t5");

    // 6: reset pulse mid-body, then restart from seq 0
    do_reset();
    mode_i = 1'b0; dest_cord_i = 4'h5;
    en_i = 2'b11; found = 1'b0;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (exp_q[0].size() != 0) begin
        found = 1'b1;
        break;
      end
    end
    @(negedge clk);
    check("t6_midbody", {63'd0, found}, 64'd1);
    reset_i = 1'b1; en_i = 2'b00;
    cyc(1);
    check("t6_v", {62'd0, v_o}, 64'd0);
    check("t6_data", data_o, 64'd0);
    check("t6_err", {62'd0, error_o}, 64'd0);
    check("t6_sent", sent_o, 64'd0);
    check("t6_recv", received_o, 64'd0);
    check("t6_done", {63'd0, done_o}, 64'd1);
    reset_i = 1'b0;
    cyc(1);
    en_i = 2'b11;
    cyc(1);
    check("t6_restart_hdr", {32'd0, data_o[31:0]}, 64'h35);
    cyc(200);
    drain();
    check_stats("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
